// File: rtl/gray_stream_arbiter.sv
// rtl/gray_stream_arbiter.sv - round-robin AXI-Stream arbiter feeding the grayscale pipeline
//
// Grants one of NUM_SRC pixel sources at a time for a burst of BURST_LEN beats and
// forwards accepted beats through a one-entry output register tagged with m_tid.
// Optional feature macro: GRAY_ARB_TIMEOUT_EN (early release after TIMEOUT idle cycles).
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   s_tdata      per-source {R,G,B}; source i at [i*3*DATA_WIDTH +: 3*DATA_WIDTH]
//   s_tvalid     per-source valid
//   s_tready     per-source ready (only the granted source can be ready)
//   m_tdata      registered pixel to the pipeline
//   m_tvalid     registered valid
//   m_tready     pipeline ready
//   m_tid        source index of m_tdata
//   grant_active high while a source holds the grant
//   grant_src    current or most recent granted source

module gray_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int SRC_WIDTH  = 2,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 5,
    parameter int TIMEOUT    = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_SRC*3*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]                s_tvalid,
    output logic [NUM_SRC-1:0]                s_tready,
    output logic [3*DATA_WIDTH-1:0]           m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [SRC_WIDTH-1:0]              m_tid,
    output logic                              grant_active,
    output logic [SRC_WIDTH-1:0]              grant_src
);

    localparam int PIX_W = 3 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] BEAT_LAST = CNT_WIDTH'(BURST_LEN - 1);

    // Elaboration guard: counters and source index must be wide enough.
    if ((BURST_LEN > (2 ** CNT_WIDTH) - 1) || (TIMEOUT > (2 ** CNT_WIDTH) - 1) ||
        (NUM_SRC > (2 ** SRC_WIDTH)) || (BURST_LEN < 1)) begin : g_bad_cfg
        $error("gray_stream_arbiter: inconsistent parameter set");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state, state_next;
    logic [SRC_WIDTH-1:0]   last_grant, last_grant_next;
    logic [SRC_WIDTH-1:0]   grant_src_next;
    logic [SRC_WIDTH-1:0]   pick;
    logic [SRC_WIDTH-1:0]   arb_idx;
    int                     arb_sum;
    logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_next;
    logic                   src_valid, src_ready, accept, burst_done, release_early;

    // Round-robin pick: walk from farthest to nearest candidate so the nearest
    // requester above last_grant wins by overwriting.
    always_comb begin
        pick    = '0;
        arb_sum = 0;
        arb_idx = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            arb_sum = (int'(last_grant) + i) % NUM_SRC;
            arb_idx = SRC_WIDTH'(arb_sum);
            if (s_tvalid[arb_idx]) begin
                pick = arb_idx;
            end
        end
    end

    assign src_valid  = s_tvalid[grant_src];
    assign src_ready  = (state == GRANT) && (!m_tvalid || m_tready);
    assign accept     = src_valid && src_ready;
    assign burst_done = accept && (beat_cnt == BEAT_LAST);

    always_comb begin
        s_tready = '0;
        if (state == GRANT) begin
            s_tready[grant_src] = !m_tvalid || m_tready;
        end
    end

    assign grant_active = (state == GRANT);

`ifdef GRAY_ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(TIMEOUT - 1);
    logic [CNT_WIDTH-1:0] idle_cnt, idle_cnt_next;

    // Consecutive granted cycles with the owner not offering data.
    always_comb begin
        idle_cnt_next = idle_cnt;
        if (state == IDLE) begin
            idle_cnt_next = '0;
        end else if (accept) begin
            idle_cnt_next = '0;
        end else if (!src_valid) begin
            idle_cnt_next = idle_cnt + CNT_WIDTH'(1);
        end
    end

    assign release_early = (state == GRANT) && !src_valid && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_next;
        end
    end
`else
    assign release_early = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        grant_src_next  = grant_src;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_src_next = pick;
                    beat_cnt_next  = '0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt + CNT_WIDTH'(1);
                end
                if (burst_done || release_early) begin
                    last_grant_next = grant_src;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_src  <= '0;
            last_grant <= SRC_WIDTH'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            grant_src  <= grant_src_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

    // Output register drains independently of the arbiter state; a load in the
    // same cycle as a drain keeps m_tvalid high for full throughput.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_tdata  <= '0;
            m_tid    <= '0;
            m_tvalid <= 1'b0;
        end else if (accept) begin
            m_tdata  <= s_tdata[int'(grant_src) * PIX_W +: PIX_W];
            m_tid    <= grant_src;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_stream_arbiter.sv
// tb/tb_gray_stream_arbiter.sv - directed self-checking bench for gray_stream_arbiter
module tb_gray_stream_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [95:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [1:0]  m_tid;
    logic        grant_active;
    logic [1:0]  grant_src;

    always #5 clk = ~clk;

    gray_stream_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tid        (m_tid),
        .grant_active (grant_active),
        .grant_src    (grant_src)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rem[4];
    int seq[4];
    bit toggle   = 1'b0;

    logic        smp_mvalid, smp_mready, smp_gact;
    logic [23:0] smp_mdata;
    logic [1:0]  smp_mtid, smp_gsrc;
    logic [3:0]  smp_sready;

    logic [25:0] mlog[$];
    int          mcyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pix(input int i, input int s);
        return {4'(i), 4'hA, 16'(s)};
    endfunction

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]          = (rem[i] > 0);
            s_tdata[i*24 +: 24]  = pix(i, seq[i]);
        end
    endtask

    // Sample at negedge, then update sources just after the following posedge.
    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        smp_mvalid = m_tvalid;
        smp_mready = m_tready;
        smp_mdata  = m_tdata;
        smp_mtid   = m_tid;
        smp_sready = s_tready;
        smp_gact   = grant_active;
        smp_gsrc   = grant_src;
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            mlog.push_back({m_tid, m_tdata});
            mcyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        if (toggle) m_tready = ~m_tready;
        apply();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_log();
        mlog.delete();
        mcyc.delete();
    endtask

    // Expect mlog[first +: n] = source src, sequence numbers base..base+n-1.
    task automatic check_run(input string tag, input int first, input int n, input int src, input int base);
        for (int k = 0; k < n; k++) begin
            if (first + k < mlog.size())
                check_eq(tag, 32'(mlog[first+k]), 32'({2'(src), pix(src, base + k)}));
        end
    endtask

    int base1, base2, base3;

    initial begin
        for (int i = 0; i < 4; i++) begin
            rem[i] = 16;
            seq[i] = 0;
        end
        rstn     = 1'b0;
        m_tready = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        apply();

        // Reset with every input active.
        for (int r = 0; r < 2; r++) begin
            step();
            check_eq("rst_mvalid", 32'(smp_mvalid), 0);
            check_eq("rst_mdata",  32'(smp_mdata),  0);
            check_eq("rst_mtid",   32'(smp_mtid),   0);
            check_eq("rst_sready", 32'(smp_sready), 0);
            check_eq("rst_gact",   32'(smp_gact),   0);
            check_eq("rst_gsrc",   32'(smp_gsrc),   0);
        end
        rstn = 1'b1;
        clear_log();

        // All four sources requesting, one burst each.
        step();
        check_eq("first_idle_gact", 32'(smp_gact), 0);
        step();
        check_eq("first_gact",   32'(smp_gact),   1);
        check_eq("first_gsrc",   32'(smp_gsrc),   0);
        check_eq("first_sready", 32'(smp_sready), 32'h1);
        check_eq("first_mvalid", 32'(smp_mvalid), 0);
        step();
        check_eq("lat_mvalid", 32'(smp_mvalid), 1);
        check_eq("lat_mtid",   32'(smp_mtid),   0);
        check_eq("lat_mdata",  32'(smp_mdata),  32'(pix(0, 0)));
        run(80);
        check_eq("rr_count", 32'(mlog.size()), 64);
        for (int s = 0; s < 4; s++) check_run("rr_beat", 16 * s, 16, s, 0);
        if (mlog.size() == 64) check_eq("rr_span", 32'(mcyc[63] - mcyc[0]), 66);

        // Only source 2, 40 beats: 16 + 16 + 8.
        clear_log();
        rem[2] = 40;
        apply();
        run(60);
        check_eq("s2_count", 32'(mlog.size()), 40);
        check_run("s2_beat", 0, 40, 2, 16);
        if (mlog.size() == 40) check_eq("s2_span", 32'(mcyc[39] - mcyc[0]), 41);
`ifdef GRAY_ARB_TIMEOUT_EN
        check_eq("s2_released", 32'(smp_gact), 0);
`else
        check_eq("s2_held_gact", 32'(smp_gact), 1);
        check_eq("s2_held_gsrc", 32'(smp_gsrc), 2);
`endif
        rem[2] = 8;
        apply();
        run(30);
        check_eq("s2_done_gact", 32'(smp_gact), 0);

        // Backpressure toggling during a burst from source 3.
        clear_log();
        base3  = seq[3];
        rem[3] = 16;
        toggle = 1'b1;
        apply();
        for (int k = 0; k < 50; k++) begin
            step();
            if (smp_gact)
                check_eq("bp_sready", 32'(smp_sready),
                         (smp_mvalid && !smp_mready) ? 32'h0 : 32'h8);
        end
        toggle   = 1'b0;
        m_tready = 1'b1;
        run(5);
        check_eq("bp_count", 32'(mlog.size()), 16);
        check_run("bp_beat", 0, 16, 3, base3);

        // Source 1 stalls after 5 beats while source 3 waits.
        clear_log();
        base1  = seq[1];
        base3  = seq[3];
        rem[1] = 5;
        rem[3] = 16;
        apply();
        run(30);
`ifdef GRAY_ARB_TIMEOUT_EN
        run(45);
        check_eq("to_count", 32'(mlog.size()), 21);
        check_run("to_s1", 0, 5, 1, base1);
        check_run("to_s3", 5, 16, 3, base3);
        if (mlog.size() >= 6) check_eq("to_gap", 32'(mcyc[5] - mcyc[4]), 10);
`else
        check_eq("starve_count", 32'(mlog.size()), 5);
        check_eq("starve_gsrc",  32'(smp_gsrc), 1);
        check_eq("starve_gact",  32'(smp_gact), 1);
        rem[1] = 11;
        apply();
        run(45);
        check_eq("resume_count", 32'(mlog.size()), 32);
        check_run("resume_s1", 0, 16, 1, base1);
        check_run("resume_s3", 16, 16, 3, base3);
`endif

        // Reset after 7 accepted beats of a source-2 burst.
        clear_log();
        base2  = seq[2];
        rem[2] = 16;
        apply();
        for (int k = 0; k < 40 && (seq[2] - base2) < 7; k++) step();
        check_eq("mid_accepted", 32'(seq[2] - base2), 7);
        check_eq("mid_gsrc", 32'(grant_src), 2);
        rem[0] = 16;
        apply();
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_mvalid", 32'(m_tvalid),     0);
        check_eq("mid_rst_mdata",  32'(m_tdata),      0);
        check_eq("mid_rst_mtid",   32'(m_tid),        0);
        check_eq("mid_rst_sready", 32'(s_tready),     0);
        check_eq("mid_rst_gact",   32'(grant_active), 0);
        check_eq("mid_rst_gsrc",   32'(grant_src),    0);
        step();
        rstn = 1'b1;
        step();
        check_eq("post_rst_idle", 32'(smp_gact), 0);
        step();
        check_eq("post_rst_gact", 32'(smp_gact), 1);
        check_eq("post_rst_gsrc", 32'(smp_gsrc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
